// File: rtl/game_pkg.sv
// game_pkg: state encoding and power-up channel indices shared by game_flow_ctrl.
package game_pkg;
  typedef enum logic [2:0] {
    WELCOME    = 3'd0,
    PLAY       = 3'd1,
    GAME_OVER  = 3'd2,
    LEVEL_DONE = 3'd3,
    PAUSE      = 3'd4
  } game_state_t;
  localparam int PWR_LIFE       = 0;
  localparam int PWR_SUPER_ROPE = 1;
  localparam int PWR_SPEED      = 2;
  localparam int PWR_IMMORTAL   = 3;
endpackage

// File: rtl/pwr_timer.sv
// pwr_timer: reloadable seconds down-counter, active while nonzero; clear beats load beats tick.
module pwr_timer #(
  parameter int SECS = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  input  logic clear,
  output logic active
);
  localparam int W = $clog2(SECS + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clear) ? '0 : load ? W'(SECS) : (tick && cnt != '0) ? cnt - W'(1) : cnt;
  assign active = cnt != '0;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game flow FSM with levels, timed power-ups, hit grace and lives.
// Optional pause (PLAY<->PAUSE on key_pause edge) enabled by defining GAME_PAUSE_EN.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int INIT_LIVES     = 3,
  parameter int MAX_LIVES      = 7,
  parameter int LIVES_W        = 3,
  parameter int NUM_LEVELS     = 4,
  parameter int LEVEL_W        = 2,
  parameter int TIME_W         = 12,
  parameter int NUM_PWR        = 4,
  parameter int PWR_SECS       = 5,
  parameter int HIT_GRACE_SECS = 2,
  parameter int DROP_PERIOD    = 3,
  parameter int LEVEL_GAP_SECS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_fire,
  input  logic                       key_left,
  input  logic                       key_right,
  input  logic                       key_pause,
  input  logic                       sec_tick,
  input  logic                       col_player_ball,
  input  logic                       col_rope_ball,
  input  logic                       col_present,
  input  logic [$clog2(NUM_PWR)-1:0] present_type,
  input  logic                       balls_cleared,
  input  logic [10:0]                player_x,
  input  logic [10:0]                rope_top_y,
  output logic [2:0]                 game_state,
  output logic [LEVEL_W-1:0]         level,
  output logic [LIVES_W-1:0]         lives,
  output logic [TIME_W-1:0]          game_time,
  output logic                       game_won,
  output logic                       rope_active,
  output logic [10:0]                rope_x,
  output logic [NUM_PWR-1:0]         pwr_active,
  output logic                       player_move_left,
  output logic                       player_move_right,
  output logic                       player_visible,
  output logic                       ball_visible,
  output logic                       presents_visible,
  output logic                       present_drop,
  output logic                       level_start
);
  localparam int PT_W = $clog2(NUM_PWR);
  localparam int DW   = $clog2(DROP_PERIOD + 1);
  localparam int GW   = $clog2(LEVEL_GAP_SECS + 1);
  game_state_t      state, state_nx;
  logic             fire_q, fire_edge, pause_edge, run, live_nx, hit, life, grace_on, rope_nx, last_level;
  logic [DW-1:0]    drop_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [LIVES_W:0] lives_sum;
  assign fire_edge = key_fire & ~fire_q;
`ifdef GAME_PAUSE_EN
  logic pause_q;
  always_ff @(posedge clk) pause_q <= reset ? 1'b0 : key_pause;
  assign pause_edge = key_pause & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = key_pause;
  assign pause_edge   = 1'b0;
`endif
  assign run        = state == PLAY;
  assign live_nx    = state_nx == PLAY || state_nx == PAUSE;
  assign last_level = level == LEVEL_W'(NUM_LEVELS - 1);
  assign hit        = run && col_player_ball && !pwr_active[PWR_IMMORTAL] && !grace_on && lives != '0;
  assign life       = run && col_present && present_type == PT_W'(PWR_LIFE);
  assign lives_sum  = {1'b0, lives} + (LIVES_W+1)'(life) - (LIVES_W+1)'(hit);
  assign game_state = state;
  always_ff @(posedge clk) state <= reset ? WELCOME : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      WELCOME:    state_nx = fire_edge ? PLAY : WELCOME;
      PLAY:       state_nx = lives == '0 ? GAME_OVER :
                             balls_cleared ? (last_level ? GAME_OVER : LEVEL_DONE) :
                             pause_edge ? PAUSE : PLAY;
      LEVEL_DONE: state_nx = (sec_tick && gap_cnt == GW'(LEVEL_GAP_SECS - 1)) ? PLAY : LEVEL_DONE;
      GAME_OVER:  state_nx = fire_edge ? WELCOME : GAME_OVER;
      PAUSE:      state_nx = pause_edge ? PLAY : PAUSE;
      default:    state_nx = WELCOME;
    endcase
  end
  always_comb begin
    player_move_left  = key_left && run;
    player_move_right = key_right && run;
    player_visible    = run || state == PAUSE;
    ball_visible      = player_visible;
    presents_visible  = player_visible;
  end
  // super rope pins the rope at the ceiling; the pinning uses this cycle's (pre-update) flag
  assign rope_nx = !live_nx ? 1'b0 : !run ? rope_active : col_rope_ball ? 1'b0 :
                   (fire_edge && !rope_active) ? 1'b1 :
                   (rope_top_y == '0 && !pwr_active[PWR_SUPER_ROPE]) ? 1'b0 : rope_active;
  always_ff @(posedge clk) begin
    if (reset) begin
      fire_q       <= 1'b0;
      lives        <= LIVES_W'(INIT_LIVES);
      level        <= '0;
      game_time    <= '0;
      game_won     <= 1'b0;
      rope_active  <= 1'b0;
      rope_x       <= '0;
      present_drop <= 1'b0;
      level_start  <= 1'b0;
      drop_cnt     <= '0;
      gap_cnt      <= '0;
    end else begin
      fire_q       <= key_fire;
      level_start  <= state_nx == PLAY && (state == WELCOME || state == LEVEL_DONE);
      present_drop <= run && sec_tick && drop_cnt == DW'(DROP_PERIOD - 1);
      drop_cnt     <= !live_nx ? '0 : !(run && sec_tick) ? drop_cnt :
                      drop_cnt == DW'(DROP_PERIOD - 1) ? '0 : drop_cnt + DW'(1);
      gap_cnt      <= state != LEVEL_DONE ? '0 : !sec_tick ? gap_cnt :
                      gap_cnt == GW'(LEVEL_GAP_SECS - 1) ? '0 : gap_cnt + GW'(1);
      rope_active  <= rope_nx;
      if (run && fire_edge && !rope_active) rope_x <= player_x;
      if (state == WELCOME) begin
        lives     <= LIVES_W'(INIT_LIVES);
        level     <= '0;
        game_time <= '0;
        game_won  <= 1'b0;
      end
      if (run) begin
        lives <= lives_sum > (LIVES_W+1)'(MAX_LIVES) ? LIVES_W'(MAX_LIVES) : lives_sum[LIVES_W-1:0];
        if (sec_tick) game_time <= game_time + TIME_W'(1);
        if (lives != '0 && balls_cleared && last_level) game_won <= 1'b1;
      end
      if (state == LEVEL_DONE && state_nx == PLAY) level <= level + LEVEL_W'(1);
    end
  end
  assign pwr_active[PWR_LIFE] = 1'b0;
  for (genvar i = 1; i < NUM_PWR; i++) begin : g_pwr
    pwr_timer #(.SECS(PWR_SECS)) u_tmr (
      .clk    (clk),
      .rst    (reset),
      .load   (run && col_present && present_type == PT_W'(i)),
      .tick   (run && sec_tick),
      .clear  (!live_nx || (i == PWR_SUPER_ROPE && run && col_rope_ball)),
      .active (pwr_active[i])
    );
  end
  pwr_timer #(.SECS(HIT_GRACE_SECS)) u_grace (
    .clk    (clk),
    .rst    (reset),
    .load   (hit),
    .tick   (run && sec_tick),
    .clear  (!live_nx),
    .active (grace_on)
  );
endmodule
